control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 150 +++++++++++++++
 tb/tb_control_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control sequencer for the 32-bit bus datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt instead of acting as NOP.
module control_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        stop,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Cout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [3:0]  alu_op,
   output logic        run,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t     state, state_nxt;
   logic [4:0] opcode;
   logic       is_alu, is_addi, is_ld, is_halt, is_legal;
   logic [3:0] alu_sel;
   logic       stop_pend, halt_req;
   logic       ir_unused;

   // Register fields are consumed by the datapath's select logic, not here.
   assign ir_unused = ^ir[26:0];
   assign opcode    = ir[31:27];

   always_comb begin
      is_alu   = 1'b0;
      is_addi  = 1'b0;
      is_ld    = 1'b0;
      is_halt  = 1'b0;
      is_legal = 1'b1;
      alu_sel  = 4'd0;
      case (opcode)
         OP_ADD:  begin is_alu = 1'b1; alu_sel = 4'd0; end
         OP_SUB:  begin is_alu = 1'b1; alu_sel = 4'd1; end
         OP_AND:  begin is_alu = 1'b1; alu_sel = 4'd2; end
         OP_OR:   begin is_alu = 1'b1; alu_sel = 4'd3; end
         OP_ADDI: is_addi = 1'b1;
         OP_LD:   is_ld   = 1'b1;
         OP_HALT: is_halt = 1'b1;
         OP_NOP:  ;
         default: is_legal = 1'b0;
      endcase
   end

   // A stop seen in any execute state is held until the instruction boundary.
   assign halt_req = stop | stop_pend;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= S_RESET;
         stop_pend <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_T0)
            stop_pend <= 1'b0;
         else if (stop && (state inside {S_T3, S_T4, S_T5, S_T6, S_T7}))
            stop_pend <= 1'b1;
         if (state == S_T3 && !is_legal)
            illegal <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET: state_nxt = S_T0;
         S_T0:    state_nxt = S_T1;
         S_T1:    state_nxt = S_T2;
         S_T2:    state_nxt = S_T3;
         S_T3: begin
            if (is_halt)
               state_nxt = S_HALT;
            else if (is_alu || is_addi || is_ld)
               state_nxt = S_T4;
`ifdef CTRL_ILLEGAL_TRAP_EN
            else if (!is_legal)
               state_nxt = S_HALT;
`endif
            else
               state_nxt = halt_req ? S_HALT : S_T0;
         end
         S_T4:    state_nxt = S_T5;
         S_T5:    state_nxt = is_ld ? S_T6 : (halt_req ? S_HALT : S_T0);
         S_T6:    state_nxt = S_T7;
         S_T7:    state_nxt = halt_req ? S_HALT : S_T0;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_RESET;
      endcase
   end

   always_comb begin
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      MDRout = 1'b0; Read = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
      Zlowout = 1'b0; Cout = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
      Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; alu_op = 4'd0;
      run = (state != S_RESET) && (state != S_HALT);
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (is_alu || is_addi) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            else if (is_ld) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
         end
         S_T4: begin
            if (is_alu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_sel; end
            else if (is_addi || is_ld) begin Cout = 1'b1; Zin = 1'b1; end
         end
         S_T5: begin
            if (is_ld) begin Zlowout = 1'b1; MARin = 1'b1; end
            else if (is_alu || is_addi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
         end
         S_T6: if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
         S_T7: if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; honours CTRL_ILLEGAL_TRAP_EN.
module tb_control_sequencer;
   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] ir = 32'h0;
   logic        stop = 1'b0;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zlowout, Cout;
   logic Gra, Grb, Grc, Rin, Rout, BAout, run, illegal;
   logic [3:0] alu_op;
   int checks = 0;
   int passed = 0;

   control_sequencer dut (
      .clock(clock), .clear(clear), .ir(ir), .stop(stop),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .Zlowout(Zlowout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .run(run),
      .illegal(illegal)
   );

   always #5 clock = ~clock;

   localparam logic [17:0] B_PCout = 18'h1 << 17, B_PCin = 18'h1 << 16, B_IncPC = 18'h1 << 15;
   localparam logic [17:0] B_MARin = 18'h1 << 14, B_MDRin = 18'h1 << 13, B_MDRout = 18'h1 << 12;
   localparam logic [17:0] B_Read = 18'h1 << 11, B_IRin = 18'h1 << 10, B_Yin = 18'h1 << 9;
   localparam logic [17:0] B_Zin = 18'h1 << 8, B_Zlow = 18'h1 << 7, B_Cout = 18'h1 << 6;
   localparam logic [17:0] B_Gra = 18'h1 << 5, B_Grb = 18'h1 << 4, B_Grc = 18'h1 << 3;
   localparam logic [17:0] B_Rin = 18'h1 << 2, B_Rout = 18'h1 << 1, B_BAout = 18'h1;
   localparam logic [17:0] F0 = B_PCout | B_MARin | B_IncPC | B_Zin;
   localparam logic [17:0] F1 = B_Zlow | B_PCin | B_Read | B_MDRin;
   localparam logic [17:0] F2 = B_MDRout | B_IRin;

   function automatic logic [17:0] strobes();
      return {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
              Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout};
   endfunction

   // Pulses clear low for one cycle; returns at the negedge of the first T0.
   task automatic do_clear();
      @(negedge clock); clear = 1'b0;
      @(negedge clock); clear = 1'b1;
      @(negedge clock);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      step(2);
      checks++;
      if ({strobes(), alu_op, run, illegal} !== 24'h0)
         $display("FAIL reset_outputs: got %h want 000000", {strobes(), alu_op, run, illegal});
      else passed++;
      clear = 1'b1;
      @(negedge clock);
      checks++;
      if (strobes() !== F0 || run !== 1'b1)
         $display("FAIL reset_first_t0: strobes %h run %b want %h run 1", strobes(), run, F0);
      else passed++;
   endtask

   task automatic test_alu_and();
      logic [17:0] exp_s [7];
      logic [3:0]  exp_a [7];
      exp_s = '{F0, F1, F2, B_Grb | B_Rout | B_Yin, B_Grc | B_Rout | B_Zin,
                B_Zlow | B_Gra | B_Rin, F0};
      exp_a = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0};
      ir = 32'h2A2B8000;
      do_clear();
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clock);
         checks++;
         if (strobes() !== exp_s[i] || alu_op !== exp_a[i] || run !== 1'b1)
            $display("FAIL and_step%0d: strobes %h alu %0d run %b want %h alu %0d run 1",
                     i, strobes(), alu_op, run, exp_s[i], exp_a[i]);
         else passed++;
      end
   endtask

   task automatic test_alu_ops();
      logic [31:0] irs [4];
      logic [17:0] exp_s [4];
      logic [3:0]  exp_a [4];
      irs   = '{32'h18000000, 32'h20000000, 32'h30000000, 32'h60000000};
      exp_s = '{B_Grc | B_Rout | B_Zin, B_Grc | B_Rout | B_Zin, B_Grc | B_Rout | B_Zin, B_Cout | B_Zin};
      exp_a = '{4'd0, 4'd1, 4'd3, 4'd0};
      for (int k = 0; k < 4; k++) begin
         ir = irs[k];
         do_clear();
         step(4);
         checks++;
         if (strobes() !== exp_s[k] || alu_op !== exp_a[k])
            $display("FAIL op%0d_t4: strobes %h alu %0d want %h alu %0d",
                     k, strobes(), alu_op, exp_s[k], exp_a[k]);
         else passed++;
      end
   endtask

   task automatic test_ld();
      logic [17:0] exp_s [9];
      exp_s = '{F0, F1, F2, B_Grb | B_BAout | B_Yin, B_Cout | B_Zin, B_Zlow | B_MARin,
                B_Read | B_MDRin, B_MDRout | B_Gra | B_Rin, F0};
      ir = 32'h00880010;
      do_clear();
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clock);
         checks++;
         if (strobes() !== exp_s[i] || alu_op !== 4'd0)
            $display("FAIL ld_step%0d: strobes %h alu %0d want %h alu 0",
                     i, strobes(), alu_op, exp_s[i]);
         else passed++;
      end
   endtask

   task automatic test_clear_mid_ld();
      ir = 32'h00880010;
      do_clear();
      step(6);
      clear = 1'b0;
      #1;
      checks++;
      if ({strobes(), alu_op, run, illegal} !== 24'h0)
         $display("FAIL clear_in_t6: got %h want 000000", {strobes(), alu_op, run, illegal});
      else passed++;
      @(negedge clock); clear = 1'b1;
      @(negedge clock);
      checks++;
      if (strobes() !== F0)
         $display("FAIL clear_resume: strobes %h want %h", strobes(), F0);
      else passed++;
   endtask

   task automatic test_halt_op();
      int bad = 0;
      ir = 32'hD8000000;
      do_clear();
      step(3);
      checks++;
      if (strobes() !== 18'h0 || run !== 1'b1)
         $display("FAIL halt_t3: strobes %h run %b want 00000 run 1", strobes(), run);
      else passed++;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (run !== 1'b0 || strobes() !== 18'h0) bad++;
      end
      checks++;
      if (bad !== 0)
         $display("FAIL halt_hold: %0d active cycles, want 0", bad);
      else passed++;
      ir = 32'h18000000;
      do_clear();
      checks++;
      if (strobes() !== F0 || run !== 1'b1)
         $display("FAIL halt_resume: strobes %h run %b want %h run 1", strobes(), run, F0);
      else passed++;
   endtask

   task automatic test_stop();
      int bad = 0;
      ir = 32'h18000000;
      do_clear();
      step(4);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      checks++;
      if (strobes() !== (B_Zlow | B_Gra | B_Rin) || run !== 1'b1)
         $display("FAIL stop_t5: strobes %h run %b want %h run 1",
                  strobes(), run, B_Zlow | B_Gra | B_Rin);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (run !== 1'b0 || PCout !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0)
         $display("FAIL stop_halt: %0d active cycles, want 0", bad);
      else passed++;
   endtask

   task automatic test_nop();
      ir = 32'hD0000000;
      do_clear();
      step(3);
      checks++;
      if (strobes() !== 18'h0 || run !== 1'b1)
         $display("FAIL nop_t3: strobes %h run %b want 00000 run 1", strobes(), run);
      else passed++;
      @(negedge clock);
      checks++;
      if (strobes() !== F0 || illegal !== 1'b0)
         $display("FAIL nop_next_t0: strobes %h illegal %b want %h illegal 0", strobes(), illegal, F0);
      else passed++;
   endtask

   task automatic test_illegal();
      ir = 32'hF8000000;
      do_clear();
      checks++;
      if (illegal !== 1'b0)
         $display("FAIL illegal_init: got %b want 0", illegal);
      else passed++;
      step(4);
`ifdef CTRL_ILLEGAL_TRAP_EN
      checks++;
      if (strobes() !== 18'h0 || run !== 1'b0 || illegal !== 1'b1)
         $display("FAIL illegal_trap: strobes %h run %b illegal %b want 00000 0 1",
                  strobes(), run, illegal);
      else passed++;
`else
      checks++;
      if (strobes() !== F0 || run !== 1'b1 || illegal !== 1'b1)
         $display("FAIL illegal_nop: strobes %h run %b illegal %b want %h 1 1",
                  strobes(), run, illegal, F0);
      else passed++;
      ir = 32'h18000000;
      step(6);
      checks++;
      if (illegal !== 1'b1)
         $display("FAIL illegal_sticky: got %b want 1", illegal);
      else passed++;
`endif
      do_clear();
      checks++;
      if (illegal !== 1'b0)
         $display("FAIL illegal_cleared: got %b want 0", illegal);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_alu_and();
      test_alu_ops();
      test_ld();
      test_clear_mid_ld();
      test_halt_op();
      test_stop();
      test_nop();
      test_illegal();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d want %0d", passed, checks);
      $fatal(1);
   end
endmodule
